// File: rtl/cv_ctrl_scanner_if.sv
// Controller-port bundle between the console scanner and the pad side:
// select strobes out, returned pin levels in, committed pad state to the CPU.
interface cv_ctrl_scanner_if;
    logic        scan_en;
    logic [7:0]  ctrl_n_i;
    logic [1:0]  fire_n_i;
    logic [1:0]  sel_kp_n_o;
    logic [1:0]  sel_joy_n_o;
    logic [11:0] joy_o;
    logic [7:0]  key_o;
    logic        valid_o;
    logic        change_o;

    modport master (
        output scan_en, ctrl_n_i, fire_n_i,
        input  sel_kp_n_o, sel_joy_n_o, joy_o, key_o, valid_o, change_o
    );

    modport slave (
        input  scan_en, ctrl_n_i, fire_n_i,
        output sel_kp_n_o, sel_joy_n_o, joy_o, key_o, valid_o, change_o
    );
endinterface

// File: rtl/cv_ctrl_scanner.sv
// ColecoVision controller port scanner: strobes keypad/joystick selects with a
// break cycle between them, samples both players, debounces and commits state.
module cv_ctrl_scanner #(
    parameter int unsigned SETTLE   = 8,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce,
    cv_ctrl_scanner_if.slave bus
);
    typedef enum logic [2:0] {IDLE, BRK1, KP, SMP_KP, BRK2, JOY, SMP_JOY, UPD} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [2:0] DEB_MAX     = 3'(DEBOUNCE);

    state_t          state_r, state_nxt_s;
    logic [7:0]      settle_r, settle_nxt_s;
    logic [1:0]      sel_kp_r, sel_joy_r, sel_kp_nxt_s, sel_joy_nxt_s;
    logic [1:0][4:0] kp_raw_r;   // {fire2, key index}
    logic [1:0][4:0] joy_raw_r;  // {fire1, up, down, left, right}
    logic [1:0][4:0] kp_smp_s, joy_smp_s;
    logic [1:0][9:0] prev_r, raw_s;
    logic [1:0][2:0] cnt_r, cnt_nxt_s;
    logic [1:0]      commit_s;
    logic [11:0]     joy_r, joy_nxt_s;
    logic [7:0]      key_r, key_nxt_s;
    logic            valid_r, change_r;
    logic            abort_s;

    function automatic logic [3:0] kp_decode(input logic [3:0] code);
        case (code)
            4'b0011: kp_decode = 4'd0;
            4'b1110: kp_decode = 4'd1;
            4'b1101: kp_decode = 4'd2;
            4'b0110: kp_decode = 4'd3;
            4'b0001: kp_decode = 4'd4;
            4'b1001: kp_decode = 4'd5;
            4'b0111: kp_decode = 4'd6;
            4'b1100: kp_decode = 4'd7;
            4'b1000: kp_decode = 4'd8;
            4'b1011: kp_decode = 4'd9;
            4'b1010: kp_decode = 4'd10;
            4'b0101: kp_decode = 4'd11;
            4'b0100: kp_decode = 4'd12;
            4'b0010: kp_decode = 4'd13;
            4'b1111: kp_decode = 4'd15;
            default: kp_decode = 4'd14;
        endcase
    endfunction

    assign abort_s = (state_r != IDLE) && !bus.scan_en;

    // Next-state, settle counter and next select levels.
    always_comb begin
        state_nxt_s  = state_r;
        settle_nxt_s = settle_r;
        if (abort_s) begin
            state_nxt_s  = IDLE;
            settle_nxt_s = 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.scan_en) begin
                        state_nxt_s = BRK1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                BRK1: begin
                    state_nxt_s  = KP;
                    settle_nxt_s = 8'd0;
                end
                KP, JOY: begin
                    if (settle_r == SETTLE_LAST) begin
                        state_nxt_s  = (state_r == KP) ? SMP_KP : SMP_JOY;
                        settle_nxt_s = 8'd0;
                    end else begin
                        settle_nxt_s = settle_r + 8'd1;
                    end
                end
                SMP_KP:  state_nxt_s = BRK2;
                BRK2: begin
                    state_nxt_s  = JOY;
                    settle_nxt_s = 8'd0;
                end
                SMP_JOY: state_nxt_s = UPD;
                UPD:     state_nxt_s = BRK1;
                default: state_nxt_s = IDLE;
            endcase
        end
        // Selects follow the state being entered so they stay registered.
        sel_kp_nxt_s  = (state_nxt_s == KP  || state_nxt_s == SMP_KP)  ? 2'b00 : 2'b11;
        sel_joy_nxt_s = (state_nxt_s == JOY || state_nxt_s == SMP_JOY) ? 2'b00 : 2'b11;
    end

    // FSM state, settle counter and select strobes.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r   <= IDLE;
            settle_r  <= 8'd0;
            sel_kp_r  <= 2'b11;
            sel_joy_r <= 2'b11;
        end else if (ce) begin
            state_r   <= state_nxt_s;
            settle_r  <= settle_nxt_s;
            sel_kp_r  <= sel_kp_nxt_s;
            sel_joy_r <= sel_joy_nxt_s;
        end else begin
            state_r   <= state_r;
            settle_r  <= settle_r;
            sel_kp_r  <= sel_kp_r;
            sel_joy_r <= sel_joy_r;
        end
    end

    // Pin sampling, raw word assembly and per-player debounce decision.
    always_comb begin
        joy_nxt_s = joy_r;
        key_nxt_s = key_r;
        for (int p = 0; p < 2; p++) begin
            kp_smp_s[p]  = {~bus.fire_n_i[p], kp_decode(bus.ctrl_n_i[p*4 +: 4])};
            joy_smp_s[p] = {~bus.fire_n_i[p], ~bus.ctrl_n_i[p*4 +: 4]};
            raw_s[p]     = {kp_raw_r[p][4], joy_raw_r[p], kp_raw_r[p][3:0]};
            if (raw_s[p] != prev_r[p]) begin
                cnt_nxt_s[p] = 3'd1;
            end else if (cnt_r[p] >= DEB_MAX) begin
                cnt_nxt_s[p] = DEB_MAX;
            end else begin
                cnt_nxt_s[p] = cnt_r[p] + 3'd1;
            end
            commit_s[p] = (cnt_nxt_s[p] == DEB_MAX);
            if (commit_s[p]) begin
                joy_nxt_s[p*6 +: 6] = raw_s[p][9:4];
                key_nxt_s[p*4 +: 4] = raw_s[p][3:0];
            end else begin
                joy_nxt_s[p*6 +: 6] = joy_r[p*6 +: 6];
                key_nxt_s[p*4 +: 4] = key_r[p*4 +: 4];
            end
        end
    end

    // Sample latches, debounce history and committed outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            kp_raw_r  <= '0;
            joy_raw_r <= '0;
            prev_r    <= '0;
            cnt_r     <= '0;
            joy_r     <= 12'h000;
            key_r     <= 8'hFF;
            valid_r   <= 1'b0;
            change_r  <= 1'b0;
        end else begin
            change_r <= 1'b0;
            if (ce) begin
                case (state_r)
                    SMP_KP:  kp_raw_r  <= kp_smp_s;
                    SMP_JOY: joy_raw_r <= joy_smp_s;
                    UPD: begin
                        prev_r <= raw_s;
                        cnt_r  <= cnt_nxt_s;
                        if (|commit_s) begin
                            joy_r    <= joy_nxt_s;
                            key_r    <= key_nxt_s;
                            valid_r  <= 1'b1;
                            change_r <= (joy_nxt_s != joy_r) || (key_nxt_s != key_r);
                        end
                    end
                    default: begin
                        kp_raw_r <= kp_raw_r;
                    end
                endcase
                // Leaving a scan early forgets the debounce history.
                if (abort_s) begin
                    cnt_r <= '0;
                end
            end
        end
    end

    assign bus.sel_kp_n_o  = sel_kp_r;
    assign bus.sel_joy_n_o = sel_joy_r;
    assign bus.joy_o       = joy_r;
    assign bus.key_o       = key_r;
    assign bus.valid_o     = valid_r;
    assign bus.change_o    = change_r;
endmodule

// File: tb/tb_cv_ctrl_scanner.sv
// Bench for cv_ctrl_scanner: emulates the pads, predicts every scan result
// from a scan-history debounce model, and runs directed plus random sequences.
module tb_cv_ctrl_scanner;
    localparam int SETTLE = 8;
    localparam int DEB    = 3;
    localparam int SCAN   = 2 * SETTLE + 5;

    logic clk_sys = 1'b0;
    logic reset;
    logic ce;

    cv_ctrl_scanner_if bus_if();

    cv_ctrl_scanner #(.SETTLE(SETTLE), .DEBOUNCE(DEB)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce      (ce),
        .bus     (bus_if.slave)
    );

    always #5 clk_sys = ~clk_sys;

    // Pad state per player: keypad pin code, pressed directions, buttons.
    logic [1:0][3:0] pad_kp;
    logic [1:0][3:0] pad_dir;
    logic [1:0]      pad_f1, pad_f2;

    function automatic logic [3:0] nib(input logic kp_n, input logic joy_n,
                                       input logic [3:0] kp, input logic [3:0] dir);
        if (!kp_n)       return kp;
        else if (!joy_n) return ~dir;
        else             return 4'hF;
    endfunction

    function automatic logic fire_pin(input logic kp_n, input logic joy_n,
                                      input logic f2, input logic f1);
        if (!kp_n)       return ~f2;
        else if (!joy_n) return ~f1;
        else             return 1'b1;
    endfunction

    assign bus_if.ctrl_n_i = {nib(bus_if.sel_kp_n_o[1], bus_if.sel_joy_n_o[1], pad_kp[1], pad_dir[1]),
                              nib(bus_if.sel_kp_n_o[0], bus_if.sel_joy_n_o[0], pad_kp[0], pad_dir[0])};
    assign bus_if.fire_n_i = {fire_pin(bus_if.sel_kp_n_o[1], bus_if.sel_joy_n_o[1], pad_f2[1], pad_f1[1]),
                              fire_pin(bus_if.sel_kp_n_o[0], bus_if.sel_joy_n_o[0], pad_f2[0], pad_f1[0])};

    typedef struct {
        logic [3:0] code;
        logic [3:0] key;
    } kp_vec_t;

    kp_vec_t     vecs[16];
    int          kp_tab[16];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          chg_cnt = 0;
    bit          gaps_on = 1'b0;
    logic [11:0] exp_joy;
    logic [7:0]  exp_key;
    logic        exp_valid, exp_change;
    logic [19:0] hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic tick(input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                ce = 1'b0;
                @(posedge clk_sys);
                #1;
            end
        end
        ce = 1'b1;
        @(posedge clk_sys);
        #1;
        ce = 1'b0;
    endtask

    function automatic logic [9:0] raw_of(input int p);
        logic [3:0] k;
        k = 4'(kp_tab[pad_kp[p]]);
        return {pad_f2[p], pad_f1[p], pad_dir[p], k};
    endfunction

    // A player's value commits once the last DEB scans all agree.
    task automatic model_scan();
        logic [19:0] w;
        logic [11:0] nj;
        logic [7:0]  nk;
        bit          any, same;
        w = {raw_of(1), raw_of(0)};
        hist.push_back(w);
        if (hist.size() > DEB) void'(hist.pop_front());
        nj  = exp_joy;
        nk  = exp_key;
        any = 1'b0;
        for (int p = 0; p < 2; p++) begin
            same = (hist.size() == DEB);
            foreach (hist[i]) if (hist[i][10*p +: 10] != w[10*p +: 10]) same = 1'b0;
            if (same) begin
                nj[6*p +: 6] = w[10*p + 4 +: 6];
                nk[4*p +: 4] = w[10*p +: 4];
                any = 1'b1;
            end
        end
        exp_change = any && ({nj, nk} != {exp_joy, exp_key});
        if (any) begin
            exp_valid = 1'b1;
            exp_joy   = nj;
            exp_key   = nk;
        end
    endtask

    // One full scan starting in the break cycle, checking strobes and results.
    task automatic do_scan();
        int         bad_sel, overlap;
        logic [1:0] ekp, ejoy;
        bad_sel = 0;
        overlap = 0;
        for (int t = 1; t <= SCAN; t++) begin
            tick(gaps_on);
            ekp  = (t <= SETTLE + 1) ? 2'b00 : 2'b11;
            ejoy = (t >= SETTLE + 3 && t <= 2 * SETTLE + 3) ? 2'b00 : 2'b11;
            if (bus_if.sel_kp_n_o !== ekp || bus_if.sel_joy_n_o !== ejoy) bad_sel++;
            if (bus_if.sel_kp_n_o != 2'b11 && bus_if.sel_joy_n_o != 2'b11) overlap++;
        end
        model_scan();
        chk("sel_pattern", bad_sel, 0);
        chk("sel_overlap", overlap, 0);
        chk("joy", bus_if.joy_o, exp_joy);
        chk("key", bus_if.key_o, exp_key);
        chk("valid", bus_if.valid_o, exp_valid);
        chk("change", bus_if.change_o, exp_change);
        if (bus_if.change_o === 1'b1) chg_cnt++;
        ce = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("change_clear", bus_if.change_o, 1'b0);
    endtask

    task automatic pads_idle();
        pad_kp  = {4'hF, 4'hF};
        pad_dir = '0;
        pad_f1  = 2'b00;
        pad_f2  = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) kp_tab[i] = 14;
        kp_tab[4'b0011] = 0;  kp_tab[4'b1110] = 1;  kp_tab[4'b1101] = 2;
        kp_tab[4'b0110] = 3;  kp_tab[4'b0001] = 4;  kp_tab[4'b1001] = 5;
        kp_tab[4'b0111] = 6;  kp_tab[4'b1100] = 7;  kp_tab[4'b1000] = 8;
        kp_tab[4'b1011] = 9;  kp_tab[4'b1010] = 10; kp_tab[4'b0101] = 11;
        kp_tab[4'b0100] = 12; kp_tab[4'b0010] = 13; kp_tab[4'b1111] = 15;
        vecs = '{'{4'b0000, 4'd14}, '{4'b0001, 4'd4},  '{4'b0010, 4'd13}, '{4'b0011, 4'd0},
                 '{4'b0100, 4'd12}, '{4'b0101, 4'd11}, '{4'b0110, 4'd3},  '{4'b0111, 4'd6},
                 '{4'b1000, 4'd8},  '{4'b1001, 4'd5},  '{4'b1010, 4'd10}, '{4'b1011, 4'd9},
                 '{4'b1100, 4'd7},  '{4'b1101, 4'd2},  '{4'b1110, 4'd1},  '{4'b1111, 4'd15}};

        pads_idle();
        reset = 1'b1;
        ce = 1'b0;
        bus_if.scan_en = 1'b0;
        exp_joy = 12'h000; exp_key = 8'hFF; exp_valid = 1'b0; exp_change = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_sel_kp", bus_if.sel_kp_n_o, 2'b11);
        chk("rst_sel_joy", bus_if.sel_joy_n_o, 2'b11);
        chk("rst_joy", bus_if.joy_o, 12'h000);
        chk("rst_key", bus_if.key_o, 8'hFF);
        chk("rst_valid", bus_if.valid_o, 1'b0);
        chk("rst_change", bus_if.change_o, 1'b0);
        reset = 1'b0;

        // Idle pads: first commit after DEB scans.
        bus_if.scan_en = 1'b1;
        tick(1'b0);
        repeat (DEB) do_scan();
        chk("idle_valid", bus_if.valid_o, 1'b1);

        // Keypad key 1 on P0.
        chg_cnt = 0;
        pad_kp[0] = 4'b1110;
        repeat (DEB) do_scan();
        chk("kp_key1", bus_if.key_o[3:0], 4'd1);
        chk("kp_key1_pulses", chg_cnt, 1);

        // Sweep every keypad code.
        for (int i = 0; i < 16; i++) begin
            pad_kp[0] = vecs[i].code;
            repeat (DEB) do_scan();
            chk("kp_sweep", {vecs[i].code, bus_if.key_o[3:0]}, {vecs[i].code, vecs[i].key});
        end

        // Joystick on P1: up + fire1, then up + fire2.
        pad_dir[1] = 4'b1000;
        pad_f1[1] = 1'b1;
        repeat (DEB) do_scan();
        chk("joy_fire1_up", bus_if.joy_o[11:6], 6'b011000);
        pad_f1[1] = 1'b0;
        pad_f2[1] = 1'b1;
        repeat (DEB) do_scan();
        chk("joy_fire2_up", bus_if.joy_o[11:6], 6'b101000);
        pads_idle();
        repeat (DEB) do_scan();

        // Two-scan glitch is rejected, three-scan hold commits.
        pad_kp[0] = 4'b1110;
        repeat (DEB) do_scan();
        chg_cnt = 0;
        pad_kp[0] = 4'b1101;
        repeat (2) do_scan();
        pad_kp[0] = 4'b1110;
        repeat (DEB) do_scan();
        chk("glitch_key", bus_if.key_o[3:0], 4'd1);
        chk("glitch_pulses", chg_cnt, 0);
        pad_kp[0] = 4'b1101;
        repeat (DEB) do_scan();
        chk("hold_key", bus_if.key_o[3:0], 4'd2);
        chk("hold_pulses", chg_cnt, 1);

        // Drop scan_en during the keypad strobe.
        repeat (3) tick(1'b0);
        chk("abort_pre_kp", bus_if.sel_kp_n_o, 2'b00);
        bus_if.scan_en = 1'b0;
        tick(1'b0);
        chk("abort_sel_kp", bus_if.sel_kp_n_o, 2'b11);
        chk("abort_sel_joy", bus_if.sel_joy_n_o, 2'b11);
        chk("abort_key_held", bus_if.key_o, exp_key);
        chk("abort_joy_held", bus_if.joy_o, exp_joy);
        repeat (5) tick(1'b0);
        chk("abort_idle_sel", {bus_if.sel_kp_n_o, bus_if.sel_joy_n_o}, 4'b1111);
        hist.delete();
        pad_kp[0] = 4'b0011;
        bus_if.scan_en = 1'b1;
        tick(1'b0);
        chg_cnt = 0;
        repeat (DEB - 1) do_scan();
        chk("resume_no_commit", chg_cnt, 0);
        do_scan();
        chk("resume_commit", bus_if.key_o[3:0], 4'd0);

        // Random pads with random ce gaps against the model.
        gaps_on = 1'b1;
        for (int r = 0; r < 40; r++) begin
            pad_kp  = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            pad_dir = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            pad_f1  = 2'($urandom_range(0, 3));
            pad_f2  = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 4)) do_scan();
        end
        gaps_on = 1'b0;

        // Reset while the joystick strobe is active.
        repeat (SETTLE + 4) tick(1'b0);
        chk("pre_rst_joy_sel", bus_if.sel_joy_n_o, 2'b00);
        reset = 1'b1;
        ce = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("mid_rst_sel_joy", bus_if.sel_joy_n_o, 2'b11);
        chk("mid_rst_sel_kp", bus_if.sel_kp_n_o, 2'b11);
        chk("mid_rst_key", bus_if.key_o, 8'hFF);
        chk("mid_rst_joy", bus_if.joy_o, 12'h000);
        chk("mid_rst_valid", bus_if.valid_o, 1'b0);
        chk("mid_rst_change", bus_if.change_o, 1'b0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cv_ctrl_scanner.md
# cv_ctrl_scanner

Console-side controller port scanner for the ColecoVision core. It drives the two active-low select strobes (keypad mode on pin 5, joystick mode on pin 8) for both controller ports and samples the returned lines (pins 1-4, 6) after a settle delay. It decodes the 4-bit keypad code, debounces every reading across scans, and presents stable per-player joystick, fire and key state to the CPU I/O logic. It is the reader for the controller-side encoder that turns MiSTer joystick bits into pin levels.

## Interface
- SETTLE, default 8: ce cycles between a select edge and sampling (1..255).
- DEBOUNCE, default 3: consecutive identical raw scans required before commit (1..7).
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable (ce_10m7); all state advances only when ce=1, except reset.
- scan_en  in  1  enables continuous scanning.
- ctrl_n_i  in  8  returned pins 1-4, active low; [3:0] = player 0 {p1,p2,p3,p4}, [7:4] = player 1.
- fire_n_i  in  2  returned pin 6 per player, active low.
- sel_kp_n_o  out  2  pin-5 strobe per player, active low.
- sel_joy_n_o  out  2  pin-8 strobe per player, active low.
- joy_o  out  12  committed state, 6 bits per player ([5:0] = P0, [11:6] = P1): {fire2, fire1, up, down, left, right}, active high.
- key_o  out  8  committed key index per player ([3:0] = P0).
- valid_o  out  1  high once the first commit has occurred.
- change_o  out  1  one-cycle pulse when any committed value changes.

## Operation
- FSM states:
  - IDLE -> BRK1 when scan_en=1.
  - BRK1: both selects high for one ce cycle.
  - KP: sel_kp_n_o=00 for SETTLE ce cycles, then SMP_KP.
  - SMP_KP: latch the keypad nibbles and fire_n_i as fire2, keeping sel_kp_n_o low.
  - BRK2: both selects high for one ce cycle.
  - JOY: sel_joy_n_o=00 for SETTLE ce cycles, then SMP_JOY.
  - SMP_JOY: latch directions as ~{p1,p2,p3,p4} = {up,down,left,right}, and ~fire_n_i as fire1.
  - UPD: debounce and commit, then -> BRK1 if scan_en, else IDLE.
- Break-before-make rule: sel_kp_n_o and sel_joy_n_o are never low in the same cycle. Both players are always strobed identically.
- Keypad decode ({p1..p4} raw level to index):
  - 0011->0, 1110->1, 1101->2, 0110->3, 0001->4, 1001->5, 0111->6, 1100->7, 1000->8, 1011->9.
  - 1010->10 (*), 0101->11 (#), 0100->12 (pt), 0010->13 (bt), 1111->15 (none).
  - Any other code -> 14 (invalid). Index 14 is debounced and committed like any other value.
- Debounce, per player, on the 10-bit raw word {fire2, fire1, dirs, key}:
  - If the raw word equals the previous raw word, increment a 3-bit counter, saturating at DEBOUNCE.
  - Otherwise, reload the counter to 1.
  - When the counter reaches DEBOUNCE in UPD, commit the raw word to joy_o/key_o.
- change_o pulses in the UPD cycle when a commit alters any output bit. valid_o sets on the first commit and holds.
- scan_en falling mid-scan: at the next ce the FSM goes to IDLE, both selects are high, committed outputs are held, and debounce counters are cleared.

## Timing
- Reset values: sel_kp_n_o=11, sel_joy_n_o=11, joy_o=0, key_o=8'hFF, valid_o=0, change_o=0, FSM=IDLE, counters=0.
- One scan takes 2*SETTLE+5 ce cycles (21 at default).
- Sampling happens in the ce cycle after the SETTLE count expires. The select is still asserted in that cycle.
- First valid_o: after DEBOUNCE scans from scan_en rising, i.e. at ce cycle DEBOUNCE*(2*SETTLE+5) at the earliest (63 at default).
- Input change to output change: between DEBOUNCE and DEBOUNCE+1 scans.
- Outputs are registered and change only in UPD. change_o is high for exactly one clk_sys cycle.
- ce=0 freezes all state; change_o is still cleared on the next clk_sys.
- Reset mid-scan: all outputs return to their reset values in the following clk_sys cycle.

## Test plan
- Idle: reset, scan_en=1, ctrl_n_i=8'hFF, fire_n_i=11.
  - Selects alternate with a break cycle; an assertion checks they are never simultaneously low.
  - After 63 ce cycles, valid_o=1, key_o=8'hFF, joy_o=0.
- Keypad decode: P0 returns 1110 during keypad select and 1111 during joystick select.
  - key_o[3:0]=1 after 3 scans, with one change_o pulse.
  - Sweep all 16 codes, including 0000 -> 14.
- Joystick: P1 returns 0111 during joystick select (p1 low) and fire_n_i[1]=0 only during joystick select.
  - joy_o[11:6]=6'b011000 (fire1 + up).
  - Pin 6 low during keypad select instead gives fire2, 6'b101000.
- Debounce: a P0 code glitch lasting 2 scans, with DEBOUNCE=3, leaves no commit and no change_o. The same glitch held for 3 scans commits.
- Abort: drop scan_en during KP.
  - The next ce shows both selects high and FSM in IDLE; outputs are held.
  - Re-enable; the next commit needs 3 fresh scans.
- Reset mid-JOY: sel_joy_n_o=11, key_o=FF and valid_o=0 in the next cycle.
